// File: rtl/wb_skid_buffer_pkg.sv
// Shared types and constants for the writeback skid buffer.
// wb_ctrl_t / lane_vec_t describe the default-width beat; the top re-derives widths from its parameters.
package wb_pkg;

  localparam int OCC_W     = 2;
  localparam int CTRL_W    = 3;
  localparam int N_DEF     = 18;
  localparam int LANES_DEF = 3;
  localparam int AW_DEF    = 4;

  typedef struct packed {
    logic              pcsrc;
    logic              regwrite;
    logic              memtoreg;
    logic [AW_DEF-1:0] wa3;
  } wb_ctrl_t;

  typedef logic [LANES_DEF-1:0][N_DEF-1:0] lane_vec_t;

  function automatic logic [OCC_W-1:0] occ_of(input logic h_vld, input logic s_vld);
    return {h_vld & s_vld, h_vld ^ s_vld};
  endfunction

endpackage

// File: rtl/wb_skid_buffer_skid.sv
// Generic 2-entry valid/ready skid buffer: head H drives the output, skid S catches a beat while H stalls.
// Latency 1 cycle when empty; in_ready comes straight from the S valid flop.
module skid_reg #(
  parameter int W     = 8,
  parameter int CLR_W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         h_valid,
  output logic         s_valid
);

  logic         r_h_vld;
  logic         r_s_vld;
  logic [W-1:0] r_h_dat;
  logic [W-1:0] r_s_dat;
  logic         w_accept;
  logic         w_load_h;

  assign w_accept = in_valid && !r_s_vld;
  assign w_load_h = !r_h_vld || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_vld <= 1'b0;
      r_s_vld <= 1'b0;
      r_h_dat <= '0;
      r_s_dat <= '0;
    end else if (flush) begin
      // Only the low CLR_W bits (control) are scrubbed; stale data stays hidden behind valid=0.
      r_h_vld              <= 1'b0;
      r_s_vld              <= 1'b0;
      r_h_dat[CLR_W-1:0]   <= '0;
      r_s_dat[CLR_W-1:0]   <= '0;
    end else if (w_load_h) begin
      if (r_s_vld) begin
        r_h_dat <= r_s_dat;
        r_h_vld <= 1'b1;
        r_s_vld <= w_accept;
        if (w_accept) begin
          r_s_dat <= in_data;
        end
      end else if (w_accept) begin
        r_h_dat <= in_data;
        r_h_vld <= 1'b1;
      end else begin
        r_h_vld <= 1'b0;
      end
    end else if (w_accept) begin
      r_s_dat <= in_data;
      r_s_vld <= 1'b1;
    end
  end

  assign in_ready  = !r_s_vld;
  assign out_valid = r_h_vld;
  assign out_data  = r_h_dat;
  assign h_valid   = r_h_vld;
  assign s_valid   = r_s_vld;

endmodule

// File: rtl/wb_skid_buffer.sv
// Writeback pipeline register: packs lane data and control into one skid_reg payload.
// Control outputs are qualified by out_valid; occupancy feeds the hazard unit.
module wb_skid_buffer
  import wb_pkg::*;
#(
  parameter int N     = 18,
  parameter int LANES = 3,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*N-1:0]   in_rd,
  input  logic [LANES*N-1:0]   in_alu,
  input  logic [AW-1:0]        in_wa3,
  input  logic                 in_pcsrc,
  input  logic                 in_regwrite,
  input  logic                 in_memtoreg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*N-1:0]   out_rd,
  output logic [LANES*N-1:0]   out_alu,
  output logic [AW-1:0]        out_wa3,
  output logic                 out_pcsrc,
  output logic                 out_regwrite,
  output logic                 out_memtoreg,
  output logic [OCC_W-1:0]     occupancy
);

  localparam int LW = LANES * N;
  localparam int W  = 2 * LW + AW + CTRL_W;

  // Same field order as wb_ctrl_t, so the control sits in the low bits that flush scrubs.
  typedef struct packed {
    logic [LW-1:0] rd;
    logic [LW-1:0] alu;
    logic          pcsrc;
    logic          regwrite;
    logic          memtoreg;
    logic [AW-1:0] wa3;
  } beat_t;

  beat_t w_in_beat;
  beat_t w_head;
  logic  w_out_vld;
  logic  w_h_vld;
  logic  w_s_vld;

  always_comb begin
    w_in_beat          = '0;
    w_in_beat.rd       = in_rd;
    w_in_beat.alu      = in_alu;
    w_in_beat.pcsrc    = in_pcsrc;
    w_in_beat.regwrite = in_regwrite;
    w_in_beat.memtoreg = in_memtoreg;
    w_in_beat.wa3      = in_wa3;
  end

  skid_reg #(
    .W     (W),
    .CLR_W (AW + CTRL_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_beat),
    .out_valid (w_out_vld),
    .out_ready (out_ready),
    .out_data  (w_head),
    .h_valid   (w_h_vld),
    .s_valid   (w_s_vld)
  );

  assign out_valid    = w_out_vld;
  assign out_rd       = w_head.rd;
  assign out_alu      = w_head.alu;
  assign out_wa3      = w_head.wa3;
  assign out_pcsrc    = w_head.pcsrc    & w_out_vld;
  assign out_regwrite = w_head.regwrite & w_out_vld;
  assign out_memtoreg = w_head.memtoreg & w_out_vld;
  assign occupancy    = occ_of(w_h_vld, w_s_vld);

endmodule
